// File: rtl/alu_issue.sv
// ALU issue stage: one-deep issue register feeding an external combinational ALU,
// with an in-order response FIFO. Optional ALU_STICKY_OVF_EN adds a sticky overflow flag.
module alu_issue #(
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_A,
  input  logic [31:0] req_B,
  input  logic [2:0]  req_op,
  input  logic [3:0]  req_tag,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [2:0]  alu_ALUop,
  input  logic [31:0] alu_Result,
  input  logic        alu_Overflow,
  input  logic        alu_CarryOut,
  input  logic        alu_Zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [2:0]  rsp_flags,
  output logic [3:0]  rsp_tag
`ifdef ALU_STICKY_OVF_EN
  ,
  input  logic        ovf_clr,
  output logic        ovf_sticky
`endif
);

  localparam int unsigned PW = $clog2(RSP_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 39;

  logic          issueValid;
  logic [31:0]   issueA;
  logic [31:0]   issueB;
  logic [2:0]    issueOp;
  logic [3:0]    issueTag;

  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] fifoCount;
  logic [EW-1:0] mem [RSP_DEPTH];
  logic [EW-1:0] head;
  logic [CW:0]   occupancy;

  logic reqFire;
  logic push;
  logic pop;

  // Issue entry reserves a FIFO slot, so the issue register always drains next edge.
  assign occupancy = {1'b0, fifoCount} + {{CW{1'b0}}, issueValid};
  assign req_ready = occupancy < (CW+1)'(RSP_DEPTH);
  assign reqFire   = req_valid && req_ready;
  assign push      = issueValid;
  assign rsp_valid = fifoCount != '0;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    alu_A     = '0;
    alu_B     = '0;
    alu_ALUop = '0;
    if (issueValid) begin
      alu_A     = issueA;
      alu_B     = issueB;
      alu_ALUop = issueOp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issueValid <= 1'b0;
      issueA     <= '0;
      issueB     <= '0;
      issueOp    <= '0;
      issueTag   <= '0;
    end else begin
      issueValid <= reqFire;
      if (reqFire) begin
        issueA   <= req_A;
        issueB   <= req_B;
        issueOp  <= req_op;
        issueTag <= req_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= {issueTag, alu_Overflow, alu_CarryOut, alu_Zero, alu_Result};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + CW'(1);
        2'b01:   fifoCount <= fifoCount - CW'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  assign head       = mem[rdPtr];
  assign rsp_result = head[31:0];
  assign rsp_flags  = head[34:32];
  assign rsp_tag    = head[38:35];

`ifdef ALU_STICKY_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (push && (issueOp == 3'b010 || issueOp == 3'b110) && alu_Overflow) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU and an in-order scoreboard.
// Sticky overflow checks are compiled when ALU_STICKY_OVF_EN is defined.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_A, req_B;
  logic [2:0]  req_op;
  logic [3:0]  req_tag;
  logic [31:0] alu_A, alu_B;
  logic [2:0]  alu_ALUop;
  logic [31:0] alu_Result;
  logic        alu_Overflow, alu_CarryOut, alu_Zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic [3:0]  rsp_tag;
`ifdef ALU_STICKY_OVF_EN
  logic        ovf_clr;
  logic        ovf_sticky;
`endif

  int passCnt  = 0;
  int totalCnt = 0;
  int popCnt   = 0;
  logic [38:0] sb[$];

  always #5 clk = ~clk;

  alu_issue #(.RSP_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_op(req_op), .req_tag(req_tag),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop),
    .alu_Result(alu_Result), .alu_Overflow(alu_Overflow),
    .alu_CarryOut(alu_CarryOut), .alu_Zero(alu_Zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag)
`ifdef ALU_STICKY_OVF_EN
    , .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
`endif
  );

  // Returns {result, Overflow, CarryOut, Zero}.
  function automatic logic [34:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic ov, co;
    s = '0; ov = 1'b0; co = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; co = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd3: r = {31'b0, a < b};
      3'd4: r = a ^ b;
      3'd5: r = ~(a | b);
      3'd6: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; co = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      default: r = {31'b0, $signed(a) < $signed(b)};
    endcase
    return {r, ov, co, r == 32'd0};
  endfunction

  assign {alu_Result, alu_Overflow, alu_CarryOut, alu_Zero} = aluModel(alu_A, alu_B, alu_ALUop);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [3:0] tag);
    req_valid = 1'b1; req_A = a; req_B = b; req_op = op; req_tag = tag;
  endtask

  // Inputs change just after posedge; at negedge they show what the next edge will transfer.
  always @(negedge clk) begin : monitor
    logic [34:0] m;
    logic [38:0] e;
    if (rst_n) begin
      if (req_valid && req_ready) begin
        m = aluModel(req_A, req_B, req_op);
        sb.push_back({req_tag, m[2:0], m[34:3]});
      end
      if (rsp_valid && rsp_ready) begin
        popCnt++;
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check("sb_result", 64'(rsp_result), 64'(e[31:0]));
          check("sb_flags", 64'(rsp_flags), 64'(e[34:32]));
          check("sb_tag", 64'(rsp_tag), 64'(e[38:35]));
        end
      end
    end
  end

  initial begin
    int acc;
    int popBase;
    logic [31:0] holdRes;
    logic [3:0]  holdTag;

    rst_n = 1'b0; req_valid = 1'b0; req_A = '0; req_B = '0; req_op = '0; req_tag = '0;
    rsp_ready = 1'b0;
`ifdef ALU_STICKY_OVF_EN
    ovf_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_alu_A", 64'(alu_A), 64'(0));
    check("rst_alu_op", 64'(alu_ALUop), 64'(0));
    rst_n = 1'b1;
    tick();

    // Overflowing add, latency 2
    rsp_ready = 1'b1;
    drive(32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 4'd5);
    check("add_req_ready", 64'(req_ready), 64'(1));
    tick();
    req_valid = 1'b0;
    check("issue_alu_A", 64'(alu_A), 64'(32'h7FFF_FFFF));
    check("issue_alu_B", 64'(alu_B), 64'(32'h0000_0001));
    check("issue_alu_op", 64'(alu_ALUop), 64'(3'b010));
    check("lat_cycle1", 64'(rsp_valid), 64'(0));
    tick();
    check("lat_cycle2", 64'(rsp_valid), 64'(1));
    check("add_result", 64'(rsp_result), 64'(32'h8000_0000));
    check("add_flags", 64'(rsp_flags), 64'(3'b100));
    check("add_tag", 64'(rsp_tag), 64'(5));
    check("idle_alu_A", 64'(alu_A), 64'(0));
    tick();
    check("add_popped", 64'(rsp_valid), 64'(0));

    // sub equal operands, then slt
    drive(32'h1234_5678, 32'h1234_5678, 3'b110, 4'd1);
    tick();
    req_valid = 1'b0;
    tick();
    check("sub_result", 64'(rsp_result), 64'(0));
    check("sub_flags", 64'(rsp_flags), 64'(3'b011));
    check("sub_tag", 64'(rsp_tag), 64'(1));
    tick();
    drive(32'hFFFF_FFFF, 32'h0000_0000, 3'b111, 4'd2);
    tick();
    req_valid = 1'b0;
    tick();
    check("slt_result", 64'(rsp_result), 64'(1));
    check("slt_tag", 64'(rsp_tag), 64'(2));
    tick();

    // Backpressure: 6 back-to-back offers against a stalled depth-4 FIFO
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive($urandom, $urandom, 3'(i), 4'(acc));
      if (req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
    check("bp_accepted", 64'(acc), 64'(4));
    check("bp_req_ready", 64'(req_ready), 64'(0));
    check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
    holdRes = rsp_result; holdTag = rsp_tag;
    tick();
    check("bp_stable_res", 64'(rsp_result), 64'(holdRes));
    check("bp_stable_tag", 64'(rsp_tag), 64'(holdTag));
    check("bp_head_tag", 64'(rsp_tag), 64'(0));
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", 64'(rsp_valid), 64'(1));
      check("drain_tag", 64'(rsp_tag), 64'(k));
      tick();
    end
    check("drain_empty", 64'(rsp_valid), 64'(0));

    // Sustained stream of 16 with rsp_ready high
    popBase = popCnt;
    for (int i = 0; i < 16; i++) begin
      drive($urandom, $urandom, 3'($urandom_range(7, 0)), 4'(i));
      check("thru_req_ready", 64'(req_ready), 64'(1));
      check("thru_rsp_valid", 64'(rsp_valid), 64'(i >= 2));
      tick();
    end
    req_valid = 1'b0;
    check("thru_tail0", 64'(rsp_valid), 64'(1));
    tick();
    check("thru_tail1", 64'(rsp_valid), 64'(1));
    tick();
    check("thru_done", 64'(rsp_valid), 64'(0));
    check("thru_count", 64'(popCnt - popBase), 64'(16));

    // Reset with 3 entries buffered
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, 3'(i), 4'(9 + i));
      tick();
    end
    req_valid = 1'b0;
    tick();
    check("rst3_valid_before", 64'(rsp_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rst3_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst3_alu_A", 64'(alu_A), 64'(0));
    tick();
    rst_n = 1'b1;
    check("rst3_req_ready", 64'(req_ready), 64'(1));
    check("rst3_valid_after", 64'(rsp_valid), 64'(0));
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst3_no_stale", 64'(rsp_valid), 64'(0));
    end
    drive(32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000, 4'd7);
    tick();
    req_valid = 1'b0;
    tick();
    check("post_rst_valid", 64'(rsp_valid), 64'(1));
    check("post_rst_tag", 64'(rsp_tag), 64'(7));
    tick();

`ifdef ALU_STICKY_OVF_EN
    check("ovf_reset", 64'(ovf_sticky), 64'(0));
    drive(32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 4'd3);
    tick();
    req_valid = 1'b0;
    ovf_clr = 1'b1;
    tick();
    check("ovf_set_wins", 64'(ovf_sticky), 64'(1));
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 64'(ovf_sticky), 64'(0));
    drive(32'h8000_0000, 32'h0000_0001, 3'b110, 4'd4);
    tick();
    req_valid = 1'b0;
    tick();
    check("ovf_sub_set", 64'(ovf_sticky), 64'(1));
    drive(32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 4'd6);
    ovf_clr = 1'b1;
    tick();
    req_valid = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_clr_alone", 64'(ovf_sticky), 64'(0));
    tick();
    check("ovf_no_ovf_add", 64'(ovf_sticky), 64'(0));
    tick();
`endif

    repeat (4) tick();
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
